// File: rtl/sha3_absorb_packer.sv
// SHA-3 absorb packer: gathers byte beats into a rate-sized block, applies
// the SHA-3 domain padding (0x06 ... 0x80) and hands blocks to a Keccak core.
// Optional: define SHA3_PACK_CHK_EN to add the sticky proto_err output that
// flags malformed s_tkeep on accepted beats.
module sha3_absorb_packer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   input  logic [WIDTH-1:0]   s_tdata,
   input  logic               s_tvalid,
   output logic               s_tready,
   input  logic               s_tlast,
   input  logic [WIDTH/8-1:0] s_tkeep,
   input  logic [1:0]         s_tuser,
   output logic [1151:0]      blk_data,
   output logic               blk_valid,
   input  logic               blk_ready,
   output logic               blk_last,
   output logic [1:0]         blk_mode
`ifdef SHA3_PACK_CHK_EN
   ,
   output logic               proto_err
`endif
);

   localparam int unsigned BeatBytes = WIDTH / 8;
   localparam int unsigned BlkBytes  = 144;

   typedef enum logic [1:0] {StFill, StPad, StOut} state_t;

   state_t         state_q;
   logic [1151:0]  buf_q;
   logic [7:0]     cnt_q;
   logic [1:0]     mode_q;
   logic           in_msg_q;    // a message is in progress (mode already latched)
   logic           pad_pend_q;  // message ended exactly on a block boundary
   logic           tready_q;
   logic           bvalid_q;
   logic           blast_q;

   logic           accept;
   logic [1:0]     eff_mode;
   int unsigned    rate;
   int unsigned    blk_rate;
   int unsigned    keep_cnt;
   int unsigned    cnt_sum;
   logic [1151:0]  fill_buf;
   logic [1151:0]  pad_buf;

   function automatic int unsigned rate_bytes(input logic [1:0] m);
      case (m)
         2'd0:    return 144;
         2'd1:    return 136;
         2'd2:    return 104;
         default: return 72;
      endcase
   endfunction

   assign accept    = s_tvalid && tready_q;
   assign s_tready  = tready_q;
   assign blk_valid = bvalid_q;
   assign blk_last  = blast_q;
   assign blk_mode  = mode_q;
   assign blk_data  = buf_q;

   // Datapath for the FILL write (with in-place padding) and the pad-only block.
   always_comb begin
      eff_mode = in_msg_q ? mode_q : s_tuser;
      rate     = rate_bytes(eff_mode);
      blk_rate = rate_bytes(mode_q);
      keep_cnt = 0;
      for (int k = 0; k < int'(BeatBytes); k++) begin
         keep_cnt = keep_cnt + 32'(s_tkeep[k]);
      end
      cnt_sum  = 32'(cnt_q) + (s_tlast ? keep_cnt : BeatBytes);
      fill_buf = buf_q;
      for (int k = 0; k < int'(BeatBytes); k++) begin
         if ((!s_tlast || s_tkeep[k]) && (32'(cnt_q) + 32'(k) < BlkBytes)) begin
            fill_buf[(32'(cnt_q) + 32'(k)) * 8 +: 8] = s_tdata[k * 8 +: 8];
         end
      end
      if (s_tlast && (cnt_sum < rate)) begin
         fill_buf[cnt_sum * 8 +: 8]   = 8'h06;
         fill_buf[(rate - 1) * 8 +: 8] = fill_buf[(rate - 1) * 8 +: 8] | 8'h80;
      end
      pad_buf                          = '0;
      pad_buf[7:0]                     = 8'h06;
      pad_buf[(blk_rate - 1) * 8 +: 8] = 8'h80;
   end

   // Main FSM with registered handshake outputs.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q    <= StFill;
         buf_q      <= '0;
         cnt_q      <= '0;
         mode_q     <= '0;
         in_msg_q   <= 1'b0;
         pad_pend_q <= 1'b0;
         tready_q   <= 1'b1;
         bvalid_q   <= 1'b0;
         blast_q    <= 1'b0;
      end else begin
         case (state_q)
            StFill: begin
               if (accept) begin
                  buf_q    <= fill_buf;
                  cnt_q    <= 8'(cnt_sum);
                  in_msg_q <= !s_tlast;
                  if (!in_msg_q) mode_q <= s_tuser;
                  if (s_tlast || (cnt_sum >= rate)) begin
                     state_q  <= StOut;
                     tready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     blast_q  <= s_tlast && (cnt_sum < rate);
                     // A last beat that exactly fills the block needs a
                     // separate pad-only block afterwards.
                     pad_pend_q <= s_tlast && (cnt_sum >= rate);
                  end
               end
            end
            StPad: begin
               buf_q      <= pad_buf;
               pad_pend_q <= 1'b0;
               state_q    <= StOut;
               bvalid_q   <= 1'b1;
               blast_q    <= 1'b1;
            end
            StOut: begin
               if (blk_ready) begin
                  buf_q    <= '0;
                  cnt_q    <= '0;
                  bvalid_q <= 1'b0;
                  blast_q  <= 1'b0;
                  if (pad_pend_q) begin
                     state_q <= StPad;
                  end else begin
                     state_q  <= StFill;
                     tready_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q  <= StFill;
               tready_q <= 1'b1;
               bvalid_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef SHA3_PACK_CHK_EN
   // Sticky flag for non-contiguous keep, or partial keep on a non-last beat.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         proto_err <= 1'b0;
      end else if (accept) begin
         if (((s_tkeep & (s_tkeep + 1'b1)) != '0) || (!s_tlast && (s_tkeep != '1))) begin
            proto_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sha3_absorb_packer.sv
// Directed self-checking bench for sha3_absorb_packer (WIDTH=16).
module tb_sha3_absorb_packer;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b0;
   logic [15:0]   s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [1:0]    s_tkeep = '0;
   logic [1:0]    s_tuser = '0;
   logic [1151:0] blk_data;
   logic          blk_valid;
   logic          blk_ready = 1'b0;
   logic          blk_last;
   logic [1:0]    blk_mode;
`ifdef SHA3_PACK_CHK_EN
   logic          proto_err;
`endif

   int checks = 0;
   int errors = 0;

   sha3_absorb_packer #(.WIDTH(16)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tready  (s_tready),
      .s_tlast   (s_tlast),
      .s_tkeep   (s_tkeep),
      .s_tuser   (s_tuser),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_last  (blk_last),
      .blk_mode  (blk_mode)
`ifdef SHA3_PACK_CHK_EN
      ,
      .proto_err (proto_err)
`endif
   );

   always #5 ACLK = ~ACLK;

   // Present one beat at a negedge and return at the negedge after it is taken.
   task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l,
                            input logic [1:0] u);
      int n = 0;
      s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
      while (!s_tready && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL send_beat_timeout: s_tready=%b required 1", s_tready);
      end
      @(negedge ACLK);
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0;
   endtask

   task automatic wait_block(output bit ok);
      int n = 0;
      while (!blk_valid && n < 300) begin
         @(negedge ACLK);
         n++;
      end
      ok = blk_valid;
   endtask

   task automatic take_block();
      blk_ready = 1'b1;
      @(negedge ACLK);
      blk_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge ACLK);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b required 1", s_tready); end
      checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", blk_valid); end
      checks++; if (blk_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b required 0", blk_last); end
      checks++; if (blk_mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d required 0", blk_mode); end
      checks++; if (blk_data !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", blk_data); end
      ARESETn = 1'b1;
      @(negedge ACLK);
   endtask

   // Empty message in the given mode: pad-only block with blk_last=1.
   task automatic test_empty(input logic [1:0] mode, input int rate, input string tag);
      logic [1151:0] exp;
      bit ok;
      exp = '0;
      exp[7:0] = 8'h06;
      exp[(rate - 1) * 8 +: 8] = 8'h80;
      send_beat(16'h0000, 2'b00, 1'b1, mode);
      checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL %s latency: blk_valid=%b required 1", tag, blk_valid); end
      wait_block(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s timeout: blk_valid=%b required 1", tag, ok); end
      checks++; if (blk_data !== exp) begin errors++; $display("FAIL %s data: got %h required %h", tag, blk_data, exp); end
      checks++; if (blk_last !== 1'b1) begin errors++; $display("FAIL %s last: got %b required 1", tag, blk_last); end
      checks++; if (blk_mode !== mode) begin errors++; $display("FAIL %s mode: got %0d required %0d", tag, blk_mode, mode); end
      take_block();
      checks++; if (s_tready !== 1'b1 || blk_valid !== 1'b0) begin errors++; $display("FAIL %s after_hs: tready=%b valid=%b required 1 0", tag, s_tready, blk_valid); end
   endtask

   // "abc" in mode 1; tuser on the last beat is a different mode and must be ignored.
   task automatic test_abc();
      logic [1151:0] exp;
      bit ok;
      exp = '0;
      exp[31:0] = 32'h0663_6261;
      exp[135 * 8 +: 8] = 8'h80;
      send_beat(16'h6261, 2'b11, 1'b0, 2'd1);
      send_beat(16'h0063, 2'b01, 1'b1, 2'd3);
      checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL abc latency: blk_valid=%b required 1", blk_valid); end
      wait_block(ok);
      checks++; if (blk_data !== exp) begin errors++; $display("FAIL abc data: got %h required %h", blk_data, exp); end
      checks++; if (blk_last !== 1'b1 || blk_mode !== 2'd1) begin errors++; $display("FAIL abc last_mode: got %b %0d required 1 1", blk_last, blk_mode); end
      take_block();
   endtask

   // 136 bytes in mode 1: full data block then a pad-only block.
   task automatic test_full_block();
      logic [1151:0] exp;
      bit ok;
      exp = '0;
      for (int i = 0; i < 136; i++) exp[i * 8 +: 8] = 8'(i + 1);
      for (int j = 0; j < 68; j++) begin
         send_beat({8'(2 * j + 2), 8'(2 * j + 1)}, 2'b11, (j == 67), 2'd1);
      end
      wait_block(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full timeout: blk_valid=%b required 1", ok); end
      checks++; if (blk_data !== exp) begin errors++; $display("FAIL full data: got %h required %h", blk_data, exp); end
      checks++; if (blk_last !== 1'b0) begin errors++; $display("FAIL full last: got %b required 0", blk_last); end
      take_block();
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full pad_tready: got %b required 0", s_tready); end
      exp = '0;
      exp[7:0] = 8'h06;
      exp[135 * 8 +: 8] = 8'h80;
      wait_block(ok);
      checks++; if (blk_data !== exp) begin errors++; $display("FAIL full pad_data: got %h required %h", blk_data, exp); end
      checks++; if (blk_last !== 1'b1) begin errors++; $display("FAIL full pad_last: got %b required 1", blk_last); end
      take_block();
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL full end_tready: got %b required 1", s_tready); end
   endtask

   // 135 bytes in mode 1: the 0x06 and 0x80 pad bytes merge into 0x86.
   task automatic test_135();
      logic [1151:0] exp;
      bit ok;
      exp = '0;
      for (int i = 0; i < 135; i++) exp[i * 8 +: 8] = 8'(i) ^ 8'h5A;
      exp[135 * 8 +: 8] = 8'h86;
      for (int j = 0; j < 67; j++) begin
         send_beat({8'(2 * j + 1) ^ 8'h5A, 8'(2 * j) ^ 8'h5A}, 2'b11, 1'b0, 2'd1);
      end
      send_beat({8'h00, 8'(134) ^ 8'h5A}, 2'b01, 1'b1, 2'd1);
      wait_block(ok);
      checks++; if (blk_data !== exp) begin errors++; $display("FAIL b135 data: got %h required %h", blk_data, exp); end
      checks++; if (blk_last !== 1'b1) begin errors++; $display("FAIL b135 last: got %b required 1", blk_last); end
      take_block();
   endtask

   // Backpressure on the block side, mode 0 (rate 144).
   task automatic test_backpressure();
      logic [1151:0] exp;
      bit ok;
      exp = '0;
      exp[31:0] = 32'h0663_6261;
      exp[143 * 8 +: 8] = 8'h80;
      send_beat(16'h6261, 2'b11, 1'b0, 2'd0);
      send_beat(16'h0063, 2'b01, 1'b1, 2'd0);
      wait_block(ok);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (blk_valid !== 1'b1 || s_tready !== 1'b0 || blk_data !== exp || blk_mode !== 2'd0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b tready=%b mode=%0d data=%h required 1 0 0 %h",
                     c, blk_valid, s_tready, blk_mode, blk_data, exp);
         end
         @(negedge ACLK);
      end
      take_block();
      checks++; if (blk_valid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL bp_hs: valid=%b tready=%b required 0 1", blk_valid, s_tready); end
   endtask

   // Reset in the middle of a mode-2 message; the next message must start clean.
   task automatic test_reset_mid();
      for (int j = 0; j < 10; j++) send_beat(16'hA5A5, 2'b11, 1'b0, 2'd2);
      ARESETn = 1'b0;
      #1;
      checks++; if (blk_valid !== 1'b0 || s_tready !== 1'b1 || blk_data !== '0) begin errors++; $display("FAIL rst_async: valid=%b tready=%b data_nz=%b required 0 1 0", blk_valid, s_tready, |blk_data); end
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK);
      checks++; if (blk_valid !== 1'b0 || s_tready !== 1'b1) begin errors++; $display("FAIL rst_release: valid=%b tready=%b required 0 1", blk_valid, s_tready); end
      test_empty(2'd1, 136, "rst_empty");
   endtask

   initial begin
      test_reset();
      test_empty(2'd1, 136, "empty_m1");
      test_abc();
      test_full_block();
      test_135();
      test_backpressure();
      test_empty(2'd3, 72, "empty_m3");
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sha3_absorb_packer.md
SHA3_ABSORB_PACKER -- requirements
Module: sha3_absorb_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, input beat width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have port ACLK, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port ARESETn, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port s_tdata, input, WIDTH, message bytes; byte k at bits [8k+7:8k], lowest byte first in message order.
REQ-005 SHALL have port s_tvalid, input, 1, beat valid.
REQ-006 SHALL have port s_tready, output, 1, beat accepted when s_tvalid and s_tready are both high.
REQ-007 SHALL have port s_tlast, input, 1, final beat of message.
REQ-008 SHALL have port s_tkeep, input, WIDTH/8, byte enables; all ones on non-last beats; contiguous from bit 0 (all zero allowed) on last beat.
REQ-009 SHALL have port s_tuser, input, 2, mode 0/1/2/3 = SHA3-224/256/384/512.
REQ-010 SHALL have port blk_data, output, 1152, padded rate block; byte n at bits [8n+7:8n]; bytes at or above rate are zero.
REQ-011 SHALL have port blk_valid, output, 1, block available.
REQ-012 SHALL have port blk_ready, input, 1, Keccak core accepts block when blk_valid and blk_ready are both high.
REQ-013 SHALL have port blk_last, output, 1, block is the final block of the message.
REQ-014 SHALL have port blk_mode, output, 2, mode of the message the block belongs to.

Function
REQ-015 SHALL use rate R bytes per mode: 0->144, 1->136, 2->104, 3->72.
REQ-016 SHALL latch s_tuser on the first accepted beat of each message; s_tuser on later beats is ignored.
REQ-017 SHALL implement FSM FILL, PAD, OUT; FILL asserts s_tready=1, PAD and OUT assert s_tready=0.
REQ-018 SHALL, in FILL, write accepted bytes at the byte counter position and advance the counter by WIDTH/8, or by popcount(s_tkeep) on the last beat.
REQ-019 SHALL, when a non-last beat brings the counter to R, enter OUT on the next cycle with blk_last=0.
REQ-020 SHALL, on a last beat leaving the counter at c<R, write 0x06 at byte c, OR 0x80 into byte R-1 (giving 0x86 when c=R-1), and enter OUT with blk_last=1.
REQ-021 SHALL, on a last beat leaving the counter at exactly R, enter OUT with blk_last=0; after that handshake it SHALL enter PAD.
REQ-022 SHALL, in PAD, build a block of zeros with byte 0 = 0x06 and byte R-1 = 0x80 in one cycle, then enter OUT with blk_last=1.
REQ-023 SHALL treat a last beat with s_tkeep all zero as adding no bytes, which allows an empty message.
REQ-024 SHALL assert blk_valid only in OUT and hold blk_data, blk_last, blk_mode stable until the handshake.
REQ-025 SHALL, on handshake in OUT, clear the buffer and counter; it SHALL go to PAD if a pad-only block is pending, else to FILL.
REQ-026 SHALL have a latency of exactly 1 cycle from the completing beat to blk_valid=1, and 1 cycle from the OUT handshake to s_tready=1.

Reset
REQ-027 SHALL, with ARESETn low, immediately force state FILL, counter 0, buffer 0, s_tready=1, blk_valid=0, blk_last=0, blk_mode=0, blk_data=0.
REQ-028 SHALL discard any partial message on reset mid-operation; the first beat after release starts a new message.

Configuration
REQ-029 SHALL, with macro SHA3_PACK_CHK_EN defined, add output proto_err (1 bit, reset 0), set sticky on an accepted beat with non-contiguous s_tkeep or with s_tkeep not all ones while s_tlast=0, and cleared only by reset.
REQ-030 SHALL, without SHA3_PACK_CHK_EN, have no proto_err port and no checking logic, with all other behaviour identical.

Verification
REQ-031 SHALL cover: mode 1, one beat with s_tlast=1 and s_tkeep=00 -> one block, byte0=0x06, byte135=0x80, all else 0, blk_last=1.
REQ-032 SHALL cover: WIDTH=16, mode 1, beats 0x6261 with keep 11 then 0x0063 with keep 01 and last -> bytes 61 62 63 06, byte135=0x80, blk_last=1.
REQ-033 SHALL cover: mode 1, a 136-byte message (68 beats) -> data block with blk_last=0, then a pad-only block (0x06...0x80) with blk_last=1.
REQ-034 SHALL cover: mode 1, a 135-byte message -> single block with byte134 = last data byte, byte135=0x86.
REQ-035 SHALL cover: blk_ready held low 5 cycles while blk_valid=1 -> s_tready=0 throughout and blk_data unchanged; handshake on the 6th cycle.
REQ-036 SHALL cover: ARESETn pulsed low after 10 beats -> blk_valid=0 and s_tready=1 after release; the next empty message yields exactly the REQ-031 block.
